ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- Synthesizable AHB-Lite responder backed by a word-addressed on-chip RAM.
- Serves as the slave end of the `ahb_lite` interface: the backing-store target for the I-cache line-fill master, and the memory model for cache benches.
- Supports a programmable number of wait states, byte/halfword/word writes, and the two-cycle ERROR response for out-of-range or misaligned accesses.

Parameters:
- ADDR_WIDTH, 32, width of haddr.
- DATA_WIDTH, 32, width of hwdata/hrdata. Fixed at 32; other values are unsupported.
- DEPTH, 1024, RAM size in 32-bit words. Must be a power of 2.
- WAIT_STATES, 0, number of hreadyout=0 cycles inserted in every OKAY data phase. Range 0..15.

Ports:
- hclk  in  1  bus clock; all state updates on the rising edge.
- hrstn  in  1  asynchronous active-low reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  byte address (address phase).
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  000 byte, 001 halfword, 010 word. Other encodings are illegal.
- hready  in  1  bus-level ready (hreadyin); qualifies address-phase sampling.
- hwdata  in  DATA_WIDTH  write data (data phase).
- hrdata  out  DATA_WIDTH  read data, valid when hreadyout=1 and hresp=0 in a read data phase.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (hrstn=0, asynchronous):
  - state=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0.
  - Any pending write is discarded.
  - RAM contents are not reset.
  - Release is synchronous to the next hclk edge.
- Address-phase capture:
  - Condition: hsel & hready & htrans[1].
  - On that edge, register addr, write, and size, and evaluate error.
  - IDLE/BUSY or hsel=0 is not a transfer; the slave returns zero-wait OKAY.
- Error condition:
  - word index haddr[ADDR_WIDTH-1:2] >= DEPTH, or
  - hsize > 010, or
  - misalignment: halfword with haddr[0]=1, or word with haddr[1:0]!=0.
- States:
  - IDLE:
    - hreadyout=1, hresp=0.
    - Valid capture with error → ERR1.
    - Valid capture with WAIT_STATES>0 → WAIT (counter=WAIT_STATES-1).
    - Valid capture with WAIT_STATES=0 → LAST.
  - WAIT:
    - hreadyout=0, hresp=0.
    - counter decrements each cycle; at counter=0 → LAST.
    - No new address is captured (hready=0 on the bus).
  - LAST (final data cycle):
    - hreadyout=1, hresp=0.
    - Write: commit hwdata to RAM on this edge, byte lanes per size/addr[1:0] (little-endian; lane k = bits 8k+7:8k).
    - Next state: same rules as IDLE, so back-to-back pipelined transfers run with zero gap.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2:
    - hreadyout=1, hresp=1.
    - The RAM is never written.
    - A new capture on this edge is accepted and follows the IDLE rules; the master normally drives IDLE here.
- Read data:
  - hrdata is a register loaded on the edge entering LAST, holding the full 32-bit word. The master selects lanes.
  - It holds its value outside read LAST cycles.
  - In error phases it is driven to 0.
- Write→read hazard:
  - Case: a write in LAST, with a read to the same word captured on the same edge (WAIT_STATES=0).
  - hrdata must return the merged word: written lanes come from hwdata, all other lanes from the RAM.
  - No stale data is allowed.
- Latency:
  - OKAY access: WAIT_STATES+1 data-phase cycles.
  - ERROR access: always 2 cycles, independent of WAIT_STATES.
- Simultaneous events: reset asserted during WAIT/ERR1 aborts immediately, with outputs at their reset values in the same cycle.

Test Plan:
- Word write then read, WAIT_STATES=0: write 0x10 = 0xDEADBEEF (NONSEQ), then read 0x10 → hrdata=0xDEADBEEF, hreadyout=1 in each data phase, hresp=0.
- Byte merge with forwarding:
  - Setup: 0x20 = 0x11223344.
  - Back-to-back transfers: write byte 0x22 = 0xAA (hwdata=0x00AA0000), then immediately read 0x20.
  - Required: hrdata=0x11AA3344.
- WAIT_STATES=3:
  - Stimulus: read 0x40.
  - Required: exactly 3 cycles of hreadyout=0, then 1 cycle of hreadyout=1 with correct data.
  - Required: a pipelined NONSEQ held on haddr during the wait cycles is captured only on the ready edge.
- Out-of-range error:
  - Stimulus: write to word DEPTH (addr 0x1000, DEPTH=1024).
  - Required: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), and RAM word 0 is unchanged.
- Misaligned access and non-transfers:
  - Word read at 0x22 → 2-cycle ERROR.
  - IDLE/BUSY htrans, or hsel=0 → hreadyout=1, hresp=0, no RAM change.
- Reset mid-wait (WAIT_STATES=5):
  - Stimulus: pull hrstn low in the 2nd wait cycle of a write.
  - Required: hreadyout=1, hresp=0, hrdata=0 at once, and the target word is unwritten after release.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting a word-addressed on-chip RAM with programmable wait
// states, sub-word writes and the two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hrstn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx_q;
  logic [1:0]              off_q;
  logic [1:0]              size_q;
  logic                    write_q;
  logic [3:0]              wait_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    capture;
  logic                    accepting;
  logic                    out_of_range;
  logic                    misaligned;
  logic                    cap_err;
  logic                    commit;
  logic [3:0]              wr_mask;
  logic [IDX_W-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign capture      = hsel & hready & htrans[1];
  assign accepting    = (state == IDLE) || (state == LAST) || (state == ERR2);
  assign out_of_range = |haddr[ADDR_WIDTH-1:IDX_W+2];
  assign misaligned   = ((hsize == 3'b001) & haddr[0]) | ((hsize == 3'b010) & (|haddr[1:0]));
  assign cap_err      = out_of_range | (hsize > 3'b010) | misaligned;
  assign commit       = (state == LAST) & write_q;
  assign wr_mask      = lane_mask(size_q, off_q);
  assign rd_idx       = (state == WAIT) ? idx_q : haddr[IDX_W+1:2];

  // A read captured while a write to the same word commits must see the new lanes.
  always_comb begin
    rd_word = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_mask[k]) rd_word[8*k +: 8] = hwdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_mask[k]) mem[idx_q][8*k +: 8] <= hwdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state     <= IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      wait_cnt  <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= LAST;
            hreadyout <= 1'b1;
            if (!write_q) hrdata <= rd_word;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ERR1: begin
          state     <= ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          if (accepting && capture) begin
            idx_q   <= haddr[IDX_W+1:2];
            off_q   <= haddr[1:0];
            size_q  <= hsize[1:0];
            write_q <= hwrite;
            if (cap_err) begin
              state     <= ERR1;
              hreadyout <= 1'b0;
              hresp     <= 1'b1;
              hrdata    <= '0;
            end else if (WAIT_STATES > 0) begin
              state     <= WAIT;
              wait_cnt  <= WAIT_INIT;
              hreadyout <= 1'b0;
              hresp     <= 1'b0;
            end else begin
              state     <= LAST;
              hreadyout <= 1'b1;
              hresp     <= 1'b0;
              if (!hwrite) hrdata <= rd_word;
            end
          end else begin
            state     <= IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 3 and 5 wait states) driven
// from one shared bus, checked every cycle against a transaction-level model.
module tb_ahb_sram_slave;

  localparam int NDUT = 3;
  localparam int WS0 = 0;
  localparam int WS1 = 3;
  localparam int WS2 = 5;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

  localparam int K_WAIT = 0;
  localparam int K_ERR1 = 1;
  localparam int K_ERR2 = 2;
  localparam int K_RD   = 3;
  localparam int K_WR   = 4;

  typedef struct {
    int          kind;
    int          idx;
    int          off;
    int          nbytes;
    logic [31:0] data;
  } entry_t;

  logic        hclk = 1'b0;
  logic        hrstn = 1'b1;
  logic [2:0]  hsel_v;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata [NDUT];
  logic        hreadyout [NDUT];
  logic        hresp [NDUT];

  entry_t      exp_q [NDUT][$];
  logic [31:0] model_mem [NDUT][1024];
  logic [31:0] cur_rd [NDUT];
  int          checks = 0;
  int          errors = 0;
  time         last_cap = 0;
  time         cap_gap = 0;

  entry_t      cmp_e;
  logic        cmp_rdy;
  logic        cmp_rsp;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.WAIT_STATES(WS0)) dut0 (
    .hclk(hclk), .hrstn(hrstn), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(hreadyout[0]), .hwdata(hwdata),
    .hrdata(hrdata[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0]));

  ahb_sram_slave #(.WAIT_STATES(WS1)) dut1 (
    .hclk(hclk), .hrstn(hrstn), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(hreadyout[1]), .hwdata(hwdata),
    .hrdata(hrdata[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1]));

  ahb_sram_slave #(.WAIT_STATES(WS2)) dut2 (
    .hclk(hclk), .hrstn(hrstn), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(hreadyout[2]), .hwdata(hwdata),
    .hrdata(hrdata[2]), .hreadyout(hreadyout[2]), .hresp(hresp[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : ((d == 1) ? WS1 : WS2);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Issue one address phase on slave d, hold it until the slave is ready,
  // then queue what the data phase must look like.
  task automatic applyStimulus(input int d, input logic sel, input logic [1:0] trans,
                               input logic wr, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int     n;
    logic   err;
    entry_t e;
    if (hclk == 1'b0) begin
      @(posedge hclk);
      #1;
    end
    hsel_v = sel ? (3'b001 << d) : 3'b000;
    haddr  = addr;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    n = 0;
    @(negedge hclk);
    while (!hreadyout[d] && n < 64) begin
      n++;
      @(negedge hclk);
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready timeout on dut%0d: got hreadyout=0 expected 1 within 64 cycles", d);
    end
    @(posedge hclk);
    if (sel && trans[1]) begin
      cap_gap  = $time - last_cap;
      last_cap = $time;
      err = ((addr >> 2) >= 1024) || (size > SZ_W) ||
            (size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 2'b00);
      e.idx    = int'(addr >> 2);
      e.off    = int'(addr[1:0]);
      e.nbytes = 1 << size;
      e.data   = wdata;
      if (err) begin
        e.kind = K_ERR1; exp_q[d].push_back(e);
        e.kind = K_ERR2; exp_q[d].push_back(e);
      end else begin
        e.kind = K_WAIT;
        for (int i = 0; i < ws_of(d); i++) exp_q[d].push_back(e);
        e.kind = wr ? K_WR : K_RD;
        exp_q[d].push_back(e);
      end
    end
    #1;
    hsel_v = 3'b000;
    htrans = T_IDLE;
    if (wr) hwdata = wdata;
  endtask

  // Per-cycle comparison of every slave against the model.
  always @(negedge hclk) begin
    for (int d = 0; d < NDUT; d++) begin
      cmp_rdy = 1'b1;
      cmp_rsp = 1'b0;
      if (!hrstn) begin
        exp_q[d].delete();
        cur_rd[d] = 32'h0;
      end else if (exp_q[d].size() != 0) begin
        cmp_e = exp_q[d].pop_front();
        case (cmp_e.kind)
          K_WAIT: cmp_rdy = 1'b0;
          K_ERR1: begin cmp_rdy = 1'b0; cmp_rsp = 1'b1; cur_rd[d] = 32'h0; end
          K_ERR2: cmp_rsp = 1'b1;
          K_RD:   cur_rd[d] = model_mem[d][cmp_e.idx];
          default: begin
            for (int b = 0; b < cmp_e.nbytes; b++) begin
              model_mem[d][cmp_e.idx][8*((cmp_e.off + b) % 4) +: 8] =
                cmp_e.data[8*((cmp_e.off + b) % 4) +: 8];
            end
          end
        endcase
      end
      checkOutput($sformatf("dut%0d hreadyout", d), 32'(hreadyout[d]), 32'(cmp_rdy));
      checkOutput($sformatf("dut%0d hresp", d), 32'(hresp[d]), 32'(cmp_rsp));
      checkOutput($sformatf("dut%0d hrdata", d), hrdata[d], cur_rd[d]);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hsel_v = 3'b000; haddr = 32'h0; htrans = T_IDLE; hwrite = 1'b0; hsize = SZ_W; hwdata = 32'h0;
    #1 hrstn = 1'b0;
    repeat (2) @(negedge hclk);
    checkOutput("reset hreadyout", 32'(hreadyout[0]), 32'd1);
    checkOutput("reset hresp", 32'(hresp[0]), 32'd0);
    checkOutput("reset hrdata", hrdata[0], 32'h0);
    hrstn = 1'b1;

    // zero wait states: word write then read, byte and halfword merges
    applyStimulus(0, 1, T_NSEQ, 1, SZ_W, 32'h10, 32'hDEADBEEF);
    applyStimulus(0, 1, T_NSEQ, 0, SZ_W, 32'h10, 32'h0);
    @(negedge hclk);
    checkOutput("read 0x10", hrdata[0], 32'hDEADBEEF);
    applyStimulus(0, 1, T_NSEQ, 1, SZ_W, 32'h20, 32'h11223344);
    applyStimulus(0, 1, T_NSEQ, 1, SZ_B, 32'h22, 32'h00AA0000);
    applyStimulus(0, 1, T_NSEQ, 0, SZ_W, 32'h20, 32'h0);
    @(negedge hclk);
    checkOutput("byte merge fwd", hrdata[0], 32'h11AA3344);
    applyStimulus(0, 1, T_NSEQ, 1, SZ_W, 32'h24, 32'hA5A5A5A5);
    applyStimulus(0, 1, T_SEQ,  1, SZ_H, 32'h26, 32'hBEEF0000);
    applyStimulus(0, 1, T_SEQ,  0, SZ_W, 32'h24, 32'h0);
    @(negedge hclk);
    checkOutput("halfword merge", hrdata[0], 32'hBEEFA5A5);

    // out-of-range write must not alias onto word 0
    applyStimulus(0, 1, T_NSEQ, 1, SZ_W, 32'h0, 32'h55AA55AA);
    applyStimulus(0, 1, T_NSEQ, 1, SZ_W, 32'h1000, 32'h12345678);
    @(negedge hclk);
    checkOutput("err1 hreadyout", 32'(hreadyout[0]), 32'd0);
    checkOutput("err1 hresp", 32'(hresp[0]), 32'd1);
    @(negedge hclk);
    checkOutput("err2 hreadyout", 32'(hreadyout[0]), 32'd1);
    checkOutput("err2 hresp", 32'(hresp[0]), 32'd1);
    applyStimulus(0, 1, T_NSEQ, 0, SZ_W, 32'h0, 32'h0);
    @(negedge hclk);
    checkOutput("word0 after oor", hrdata[0], 32'h55AA55AA);

    // misaligned / illegal size, then non-transfers
    applyStimulus(0, 1, T_NSEQ, 0, SZ_W, 32'h22, 32'h0);
    applyStimulus(0, 1, T_NSEQ, 0, 3'b011, 32'h20, 32'h0);
    applyStimulus(0, 1, T_NSEQ, 1, SZ_H, 32'h21, 32'hFFFFFFFF);
    applyStimulus(0, 1, T_IDLE, 1, SZ_W, 32'h0, 32'hFFFFFFFF);
    applyStimulus(0, 1, T_BUSY, 1, SZ_W, 32'h0, 32'hFFFFFFFF);
    applyStimulus(0, 0, T_NSEQ, 1, SZ_W, 32'h0, 32'hFFFFFFFF);
    applyStimulus(0, 1, T_NSEQ, 0, SZ_W, 32'h0, 32'h0);
    @(negedge hclk);
    checkOutput("word0 after non-transfers", hrdata[0], 32'h55AA55AA);

    // three wait states with a pipelined address held across the waits
    applyStimulus(1, 1, T_NSEQ, 1, SZ_W, 32'h40, 32'hC0FFEE00);
    applyStimulus(1, 1, T_NSEQ, 1, SZ_W, 32'h44, 32'h01020304);
    applyStimulus(1, 1, T_NSEQ, 0, SZ_W, 32'h40, 32'h0);
    applyStimulus(1, 1, T_NSEQ, 0, SZ_W, 32'h44, 32'h0);
    checkOutput("ws3 capture spacing", 32'(cap_gap), 32'd40);
    repeat (4) @(negedge hclk);
    checkOutput("ws3 read 0x44", hrdata[1], 32'h01020304);
    applyStimulus(1, 1, T_NSEQ, 0, SZ_H, 32'h41, 32'h0);
    @(negedge hclk);
    checkOutput("ws3 err1 hresp", 32'(hresp[1]), 32'd1);

    // five wait states: reset in the second wait cycle of a write
    applyStimulus(2, 1, T_NSEQ, 1, SZ_W, 32'h80, 32'h12345678);
    applyStimulus(2, 1, T_NSEQ, 0, SZ_W, 32'h80, 32'h0);
    applyStimulus(2, 1, T_NSEQ, 1, SZ_W, 32'h80, 32'hCAFEF00D);
    checkOutput("ws5 read before reset", hrdata[2], 32'h12345678);
    @(posedge hclk);
    #1 hrstn = 1'b0;
    #1;
    checkOutput("mid-wait reset hreadyout", 32'(hreadyout[2]), 32'd1);
    checkOutput("mid-wait reset hresp", 32'(hresp[2]), 32'd0);
    checkOutput("mid-wait reset hrdata", hrdata[2], 32'h0);
    repeat (2) @(negedge hclk);
    hrstn = 1'b1;
    applyStimulus(2, 1, T_NSEQ, 0, SZ_W, 32'h80, 32'h0);
    repeat (6) @(negedge hclk);
    checkOutput("aborted write discarded", hrdata[2], 32'h12345678);

    repeat (3) @(negedge hclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
